// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and dispatch FSM feeding the uart_tx serialiser.
// Optional low-watermark interrupt: define UART_TX_FIFO_THRESH_IRQ_EN.
module uart_tx_fifo #(
    parameter  int DEPTH     = 16,
    parameter  int DATA_BITS = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 flush,
    input  logic                 ovf_clr,
    input  logic                 tx_busy,
    output logic                 tx_en,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          level,
    output logic                 overflow,
    output logic                 active,
    input  logic [AW:0]          thresh,
    output logic                 irq
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_wait_cnt;
    logic                   w_wait_cnt_nxt;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_ovf_set;
    logic                   w_tx_en;
    logic [AW:0]            w_level_nxt;

    logic [DATA_BITS-1:0]   r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_level;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_overflow;
    logic [DATA_BITS-1:0]   r_tx_data;

    assign w_push    = wr_en && !r_full && !flush;
    assign w_ovf_set = wr_en && r_full && !flush;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_pop          = 1'b0;
        w_tx_en        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && !tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_tx_en        = 1'b1;
                w_wait_cnt_nxt = 1'b0;
                w_state_nxt    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // A serialiser that never raises busy within two cycles is treated as done.
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_wait_cnt) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == LVL_FULL);
            r_empty    <= (w_level_nxt == '0);
            // The popped byte is captured even when a flush lands on the same edge.
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef UART_TX_FIFO_THRESH_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_level <= thresh);
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_thresh;

    assign w_unused_thresh = ^thresh;
    assign irq             = 1'b0;
`endif

    assign tx_en    = w_tx_en;
    assign tx_data  = r_tx_data;
    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign active   = (r_state != S_IDLE);

endmodule
